// File: rtl/dijkstra_path_tracer_pkg.sv
// Shared widths, sentinel value and state encoding for the Dijkstra path tracer.
// Imported by the tracer top and its path stack.
package dijkstra_path_tracer_pkg;

   localparam int DEFAULT_MADDR_WIDTH = 32;
   localparam int DEFAULT_MDATA_WIDTH = 32;
   localparam int DEFAULT_MAX_NODES   = 16;
   localparam int DEFAULT_INDEX_WIDTH = 8;
   localparam int DEFAULT_VALUE_WIDTH = 16;

   localparam logic [DEFAULT_INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;

   typedef enum logic [2:0] {
      TRACER_IDLE      = 3'd0,
      TRACER_CHECK     = 3'd1,
      TRACER_READ_PREV = 3'd2,
      TRACER_READ_EDGE = 3'd3,
      TRACER_EMIT      = 3'd4,
      TRACER_DONE      = 3'd5
   } tracer_state_e;

endpackage

// File: rtl/dijkstra_path_tracer_path_stack.sv
// LIFO holding the path while it is traced backwards from the destination.
// Pushes into a full stack and pops from an empty one are ignored; clear wins.
module path_stack #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    top_ptr;
   logic             full;
   logic             empty;
   logic             unused_ptr;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign top_ptr    = count_q - CW'(1);
   assign top        = empty ? '0 : mem_q[top_ptr[AW-1:0]];
   assign count      = count_q;
   assign unused_ptr = ^top_ptr[CW-1:AW];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (push && !full) begin
         count_q <= count_q + CW'(1);
      end else if (pop && !empty) begin
         count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: occupancy alone defines what is valid.
   always_ff @(posedge clock) begin
      if (push && !full && !clear) begin
         mem_q[count_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/dijkstra_path_tracer.sv
// Walks prev[] from destination back to source, sums edge weights, then streams
// the path source-first. Reads hold enable/address until ready; one idle cycle between reads.
module dijkstra_path_tracer
   import dijkstra_path_tracer_pkg::*;
#(
   parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
   parameter int MAX_NODES   = DEFAULT_MAX_NODES,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [INDEX_WIDTH-1:0] source,
   input  logic [INDEX_WIDTH-1:0] destination,
   input  logic [INDEX_WIDTH-1:0] number_of_nodes,
   input  logic [MADDR_WIDTH-1:0] base_address,
   output logic                   mem_read_enable,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   input  logic                   mem_read_ready,
   input  logic [MDATA_WIDTH-1:0] mem_read_data,
   output logic [INDEX_WIDTH-1:0] path_node,
   output logic                   path_valid,
   input  logic                   path_ready,
   output logic                   path_last,
   output logic [INDEX_WIDTH-1:0] path_length,
   output logic [VALUE_WIDTH-1:0] path_cost,
   output logic                   done,
   output logic                   no_path,
   output logic                   loop_error,
   output tracer_state_e          debug_state
);
   localparam int STRIDE = MADDR_WIDTH / 8;
   localparam int PW     = 2 * INDEX_WIDTH;
   localparam int CW     = $clog2(MAX_NODES + 1);

   tracer_state_e          state_q;
   logic [INDEX_WIDTH-1:0] src_q, dst_q, n_q, cur_q, p_q, count_q, node_q, len_q;
   logic [MADDR_WIDTH-1:0] base_q, addr_q;
   logic [VALUE_WIDTH-1:0] cost_q, cost_d;
   logic                   en_q, valid_q, last_q, done_q, no_path_q, loop_q;

   logic                   push, pop, clear;
   logic [INDEX_WIDTH-1:0] push_data, stack_top, rd_index;
   logic [CW-1:0]          occ;
   logic                   range_bad, p_bad;
   logic [VALUE_WIDTH:0]   cost_sum;
   logic                   unused_data;

   function automatic logic [MADDR_WIDTH-1:0] word_addr(input logic [PW-1:0] idx);
      logic [PW-1:0] off;
      off = idx * PW'(STRIDE);
      return base_q + MADDR_WIDTH'(off);
   endfunction

   function automatic logic [MADDR_WIDTH-1:0] prev_addr(input logic [INDEX_WIDTH-1:0] j);
      return word_addr(PW'(n_q) * PW'(n_q) + PW'(j));
   endfunction

   function automatic logic [MADDR_WIDTH-1:0] edge_addr(input logic [INDEX_WIDTH-1:0] r,
                                                        input logic [INDEX_WIDTH-1:0] c);
      return word_addr(PW'(r) * PW'(n_q) + PW'(c));
   endfunction

   assign rd_index    = mem_read_data[INDEX_WIDTH-1:0];
   assign cost_sum    = {1'b0, cost_q} + {1'b0, mem_read_data[VALUE_WIDTH-1:0]};
   assign cost_d      = cost_sum[VALUE_WIDTH] ? '1 : cost_sum[VALUE_WIDTH-1:0];
   assign range_bad   = (src_q >= n_q) || (dst_q >= n_q);
   assign p_bad       = (p_q == INDEX_WIDTH'(NO_PREVIOUS_NODE)) || (p_q >= n_q);
   assign unused_data = ^mem_read_data[MDATA_WIDTH-1:VALUE_WIDTH];

   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      clear     = 1'b0;
      push_data = p_q;
      unique case (state_q)
         TRACER_IDLE, TRACER_DONE: clear = start;
         TRACER_CHECK: begin
            push      = !range_bad;
            push_data = dst_q;
         end
         TRACER_READ_PREV: clear = !en_q && (p_bad || (count_q == n_q));
         TRACER_READ_EDGE: push  = en_q && mem_read_ready;
         TRACER_EMIT:      pop   = !valid_q || (path_ready && !last_q);
         default: ;
      endcase
   end

   path_stack #(.DEPTH(MAX_NODES), .WIDTH(INDEX_WIDTH), .CW(CW)) u_stack (
      .clock(clock), .reset(reset), .push(push), .pop(pop), .clear(clear),
      .push_data(push_data), .top(stack_top), .count(occ)
   );

   // en_q doubles as the phase bit of the two read states: high = waiting, low = data in hand.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= TRACER_IDLE;
         src_q <= '0; dst_q <= '0; n_q <= '0; base_q <= '0;
         cur_q <= '0; p_q <= '0; count_q <= '0; cost_q <= '0;
         en_q <= 1'b0; addr_q <= '0;
         node_q <= '0; valid_q <= 1'b0; last_q <= 1'b0; len_q <= '0;
         done_q <= 1'b0; no_path_q <= 1'b0; loop_q <= 1'b0;
      end else begin
         unique case (state_q)
            TRACER_IDLE, TRACER_DONE: begin
               if (start) begin
                  src_q <= source; dst_q <= destination;
                  n_q <= number_of_nodes; base_q <= base_address;
                  done_q <= 1'b0; no_path_q <= 1'b0; loop_q <= 1'b0;
                  len_q <= '0; cost_q <= '0; node_q <= '0; last_q <= 1'b0;
                  state_q <= TRACER_CHECK;
               end
            end
            TRACER_CHECK: begin
               if (range_bad) begin
                  no_path_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= TRACER_DONE;
               end else begin
                  cur_q   <= dst_q;
                  count_q <= INDEX_WIDTH'(1);
                  cost_q  <= '0;
                  if (dst_q == src_q) begin
                     state_q <= TRACER_EMIT;
                  end else begin
                     en_q    <= 1'b1;
                     addr_q  <= prev_addr(dst_q);
                     state_q <= TRACER_READ_PREV;
                  end
               end
            end
            TRACER_READ_PREV: begin
               if (en_q) begin
                  if (mem_read_ready) begin
                     p_q  <= rd_index;
                     en_q <= 1'b0;
                  end
               end else if (p_bad) begin
                  no_path_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= TRACER_DONE;
               end else if (count_q == n_q) begin
                  loop_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= TRACER_DONE;
               end else begin
                  en_q    <= 1'b1;
                  addr_q  <= edge_addr(p_q, cur_q);
                  state_q <= TRACER_READ_EDGE;
               end
            end
            TRACER_READ_EDGE: begin
               if (en_q) begin
                  if (mem_read_ready) begin
                     cost_q  <= cost_d;
                     cur_q   <= p_q;
                     count_q <= count_q + INDEX_WIDTH'(1);
                     en_q    <= 1'b0;
                  end
               end else if (cur_q == src_q) begin
                  state_q <= TRACER_EMIT;
               end else begin
                  en_q    <= 1'b1;
                  addr_q  <= prev_addr(cur_q);
                  state_q <= TRACER_READ_PREV;
               end
            end
            TRACER_EMIT: begin
               if (!valid_q) begin
                  node_q  <= stack_top;
                  valid_q <= 1'b1;
                  last_q  <= (occ == CW'(1));
                  len_q   <= INDEX_WIDTH'(occ);
               end else if (path_ready) begin
                  if (last_q) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= TRACER_DONE;
                  end else begin
                     node_q <= stack_top;
                     last_q <= (occ == CW'(1));
                  end
               end
            end
            default: state_q <= TRACER_IDLE;
         endcase
      end
   end

   assign mem_read_enable = en_q;
   assign mem_addr        = addr_q;
   assign path_node       = node_q;
   assign path_valid      = valid_q;
   assign path_last       = last_q;
   assign path_length     = len_q;
   assign path_cost       = cost_q;
   assign done            = done_q;
   assign no_path         = no_path_q;
   assign loop_error      = loop_q;
   assign debug_state     = state_q;

endmodule

// File: tb/tb_dijkstra_path_tracer.sv
// Bench for dijkstra_path_tracer: memory responder with programmable wait, stream sink
// with programmable backpressure, and a queue-based reference trace of prev[]/graph[].
module tb_dijkstra_path_tracer;
   import dijkstra_path_tracer_pkg::*;

   localparam int AW = 32, DW = 32, IW = 8, VW = 16, MN = 16;

   logic          clock, reset, start;
   logic [IW-1:0] source, destination, number_of_nodes;
   logic [AW-1:0] base_address;
   logic          mem_read_enable, mem_read_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_read_data;
   logic [IW-1:0] path_node, path_length;
   logic          path_valid, path_ready, path_last;
   logic [VW-1:0] path_cost;
   logic          done, no_path, loop_error;
   tracer_state_e debug_state;

   dijkstra_path_tracer #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .MAX_NODES(MN),
                          .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
      .clock(clock), .reset(reset), .start(start), .source(source),
      .destination(destination), .number_of_nodes(number_of_nodes),
      .base_address(base_address), .mem_read_enable(mem_read_enable),
      .mem_addr(mem_addr), .mem_read_ready(mem_read_ready),
      .mem_read_data(mem_read_data), .path_node(path_node),
      .path_valid(path_valid), .path_ready(path_ready), .path_last(path_last),
      .path_length(path_length), .path_cost(path_cost), .done(done),
      .no_path(no_path), .loop_error(loop_error), .debug_state(debug_state)
   );

   int checks, errors;
   int cyc, start_cyc;

   logic [7:0]  prev_m  [0:15];
   logic [15:0] graph_m [0:15][0:15];
   logic [31:0] mem_words [0:1023];
   logic [7:0]  exp_q[$];

   int mem_wait, ready_mode;
   int read_count, req_start_count, first_req_cyc, addr_unstable, gap_viol, bad_addr;
   int req_cyc_q[$];
   logic [7:0] got_node_q[$];
   logic       got_last_q[$];
   int valid_cycles, node_unstable, last_hs_cyc, done_cyc;

   // ---------------- clock / cycle counter ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   // ---------------- memory responder ----------------
   initial begin : responder
      int wait_cnt;
      logic prev_ready;
      logic [AW-1:0] req_addr;
      logic [31:0] word;
      wait_cnt = 0; prev_ready = 1'b0; req_addr = '0;
      forever begin
         @(negedge clock);
         if (mem_read_enable) begin
            if (prev_ready) gap_viol++;
            if (wait_cnt == 0) begin
               req_addr = mem_addr;
               req_start_count++;
               if (first_req_cyc < 0) first_req_cyc = cyc;
            end else if (mem_addr !== req_addr) begin
               addr_unstable++;
            end
            if (wait_cnt >= mem_wait) begin
               word = (mem_addr - base_address) >> 2;
               if (word < 1024) mem_read_data = mem_words[word[9:0]];
               else begin
                  mem_read_data = '1;
                  bad_addr++;
               end
               mem_read_ready = 1'b1;
               read_count++;
               req_cyc_q.push_back(cyc);
               wait_cnt = 0;
               prev_ready = 1'b1;
            end else begin
               mem_read_ready = 1'b0;
               wait_cnt++;
               prev_ready = 1'b0;
            end
         end else begin
            mem_read_ready = 1'b0;
            wait_cnt = 0;
            prev_ready = 1'b0;
         end
      end
   end

   // ---------------- stream sink / monitor ----------------
   initial begin : sink
      logic prev_stall, done_prev;
      logic [7:0] stall_node;
      prev_stall = 1'b0; done_prev = 1'b0; stall_node = '0;
      forever begin
         @(negedge clock);
         case (ready_mode)
            0:       path_ready = 1'b1;
            1:       path_ready = ~path_ready;
            default: path_ready = 1'($urandom_range(0, 1));
         endcase
         if (path_valid) begin
            valid_cycles++;
            if (prev_stall && path_node !== stall_node) node_unstable++;
            if (path_ready) begin
               got_node_q.push_back(path_node);
               got_last_q.push_back(path_last);
               last_hs_cyc = cyc;
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               stall_node = path_node;
            end
         end else begin
            prev_stall = 1'b0;
         end
         if (done && !done_prev) done_cyc = cyc;
         done_prev = done;
      end
   end

   // ---------------- helpers (stimulus and model only) ----------------
   task automatic clear_collectors();
      read_count = 0; req_start_count = 0; first_req_cyc = -1;
      addr_unstable = 0; gap_viol = 0; bad_addr = 0; req_cyc_q.delete();
      got_node_q.delete(); got_last_q.delete();
      valid_cycles = 0; node_unstable = 0; last_hs_cyc = -1; done_cyc = -1;
   endtask

   task automatic load_mem(input int n);
      for (int w = 0; w < 1024; w++) mem_words[w] = 32'h0000_00FE;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) mem_words[r*n + c] = {16'h0, graph_m[r][c]};
      for (int j = 0; j < n; j++) mem_words[n*n + j] = {24'h0, prev_m[j]};
   endtask

   task automatic setup_chain();
      for (int r = 0; r < 16; r++) begin
         prev_m[r] = 8'hFF;
         for (int c = 0; c < 16; c++) graph_m[r][c] = 16'(100 + $urandom_range(0, 50));
      end
      for (int i = 1; i < 8; i++) prev_m[i] = 8'(i - 1);
      for (int i = 0; i < 7; i++) graph_m[i][i+1] = 16'(i + 1);
   endtask

   // kind: 0 = path found, 1 = no path, 2 = loop
   task automatic model_trace(input int s, input int d, input int n,
                              output int kind, output int unsigned cost, output int reads);
      logic [7:0] rev[$];
      int cur, p;
      exp_q.delete(); kind = 0; cost = 0; reads = 0;
      if (s >= n || d >= n) begin
         kind = 1;
         return;
      end
      cur = d;
      rev.push_back(8'(d));
      while (cur != s) begin
         p = int'(prev_m[cur]);
         reads++;
         if (p == 255 || p >= n) begin
            kind = 1;
            return;
         end
         if (rev.size() == n) begin
            kind = 2;
            return;
         end
         cost += graph_m[p][cur];
         if (cost > 65535) cost = 65535;
         reads++;
         cur = p;
         rev.push_back(8'(p));
      end
      while (rev.size() > 0) exp_q.push_back(rev.pop_back());
   endtask

   task automatic run_dut(input int s, input int d, input int n, input bit busy_start);
      bit finished;
      clear_collectors();
      source = 8'(s); destination = 8'(d); number_of_nodes = 8'(n);
      @(negedge clock);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clock);
      start = 1'b0;
      finished = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (busy_start && i == 6) begin
            source = 8'd1; destination = 8'd2; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         if (done) begin
            finished = 1'b1;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL done_timeout: done still %b after 4000 cycles, want 1", done);
      end
      repeat (3) @(negedge clock);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({mem_read_enable, mem_addr, path_node, path_valid, path_last, path_length,
           path_cost, done, no_path, loop_error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: en=%b addr=%h node=%0d valid=%b done=%b cost=%0d, want all 0",
                  mem_read_enable, mem_addr, path_node, path_valid, done, path_cost);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (debug_state !== TRACER_IDLE || path_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: state=%0d valid=%b done=%b, want IDLE 0 0",
                  debug_state, path_valid, done);
      end
   endtask

   task automatic test_chain();
      int kind, ereads;
      int unsigned ecost;
      setup_chain(); load_mem(8); mem_wait = 0; ready_mode = 0;
      model_trace(0, 7, 8, kind, ecost, ereads);
      run_dut(0, 7, 8, 1'b0);
      checks++;
      if (got_node_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL chain_count: got %0d nodes, want %0d", got_node_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_node_q.size(); i++) begin
         checks++;
         if (got_node_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
            errors++;
            $display("FAIL chain_node[%0d]: got %0d last=%b, want %0d last=%b", i,
                     got_node_q[i], got_last_q[i], exp_q[i], (i == exp_q.size() - 1));
         end
      end
      checks++;
      if (path_length !== 8'd8 || path_cost !== 16'(ecost) || ecost != 28) begin
         errors++;
         $display("FAIL chain_totals: length=%0d cost=%0d, want 8 28", path_length, path_cost);
      end
      checks++;
      if (done !== 1'b1 || no_path !== 1'b0 || loop_error !== 1'b0) begin
         errors++;
         $display("FAIL chain_flags: done=%b no_path=%b loop=%b, want 1 0 0", done, no_path, loop_error);
      end
      checks++;
      if (first_req_cyc != start_cyc + 2) begin
         errors++;
         $display("FAIL chain_first_read: at cycle %0d, want %0d", first_req_cyc, start_cyc + 2);
      end
      checks++;
      if (req_cyc_q.size() < 14 || req_cyc_q[2] - req_cyc_q[0] != 4 || req_cyc_q[12] - req_cyc_q[10] != 4) begin
         errors++;
         $display("FAIL chain_hop_period: %0d reads, hop spacing not 4 cycles", req_cyc_q.size());
      end
      checks++;
      if (read_count != ereads || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL chain_timing: reads=%0d done_cyc=%0d, want reads=%0d done_cyc=%0d",
                  read_count, done_cyc, ereads, last_hs_cyc + 1);
      end
   endtask

   task automatic test_single();
      setup_chain(); load_mem(8); mem_wait = 0; ready_mode = 0;
      run_dut(3, 3, 8, 1'b0);
      checks++;
      if (got_node_q.size() != 1 || got_node_q[0] !== 8'd3 || got_last_q[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_stream: %0d nodes, first=%0d, want one node 3 with last",
                  got_node_q.size(), (got_node_q.size() > 0) ? got_node_q[0] : 8'hFF);
      end
      checks++;
      if (path_length !== 8'd1 || path_cost !== 16'd0 || read_count != 0 || done !== 1'b1) begin
         errors++;
         $display("FAIL single_totals: length=%0d cost=%0d reads=%0d done=%b, want 1 0 0 1",
                  path_length, path_cost, read_count, done);
      end
   endtask

   task automatic test_no_path();
      setup_chain(); prev_m[5] = 8'hFF; load_mem(8); mem_wait = 0; ready_mode = 0;
      run_dut(0, 5, 8, 1'b0);
      checks++;
      if (no_path !== 1'b1 || loop_error !== 1'b0 || done !== 1'b1 || valid_cycles != 0) begin
         errors++;
         $display("FAIL no_path_flags: no_path=%b loop=%b done=%b valid_cycles=%0d, want 1 0 1 0",
                  no_path, loop_error, done, valid_cycles);
      end
      checks++;
      if (path_length !== 8'd0 || read_count != 1) begin
         errors++;
         $display("FAIL no_path_len: length=%0d reads=%0d, want 0 1", path_length, read_count);
      end
      run_dut(0, 8, 8, 1'b0);
      checks++;
      if (no_path !== 1'b1 || read_count != 0 || valid_cycles != 0) begin
         errors++;
         $display("FAIL range_no_path: no_path=%b reads=%0d valid_cycles=%0d, want 1 0 0",
                  no_path, read_count, valid_cycles);
      end
   endtask

   task automatic test_loop();
      int kind, ereads;
      int unsigned ecost;
      setup_chain(); prev_m[3] = 8'd4; prev_m[4] = 8'd3; load_mem(8);
      mem_wait = 0; ready_mode = 0;
      model_trace(0, 3, 8, kind, ecost, ereads);
      run_dut(0, 3, 8, 1'b0);
      checks++;
      if (loop_error !== (kind == 2) || no_path !== 1'b0 || done !== 1'b1 || valid_cycles != 0) begin
         errors++;
         $display("FAIL loop_flags: loop=%b no_path=%b done=%b valid_cycles=%0d, want 1 0 1 0",
                  loop_error, no_path, done, valid_cycles);
      end
      checks++;
      if (read_count != ereads) begin
         errors++;
         $display("FAIL loop_reads: got %0d reads, want %0d", read_count, ereads);
      end
   endtask

   task automatic test_backpressure();
      int kind, ereads;
      int unsigned ecost;
      setup_chain(); load_mem(8); mem_wait = 3; ready_mode = 1;
      model_trace(0, 7, 8, kind, ecost, ereads);
      run_dut(0, 7, 8, 1'b1);
      checks++;
      if (got_node_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_count: got %0d nodes, want %0d", got_node_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_node_q.size(); i++) begin
         checks++;
         if (got_node_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
            errors++;
            $display("FAIL bp_node[%0d]: got %0d last=%b, want %0d", i, got_node_q[i],
                     got_last_q[i], exp_q[i]);
         end
      end
      checks++;
      if (path_cost !== 16'(ecost) || path_length !== 8'd8) begin
         errors++;
         $display("FAIL bp_totals: cost=%0d length=%0d, want %0d 8", path_cost, path_length, ecost);
      end
      checks++;
      if (node_unstable != 0 || addr_unstable != 0 || gap_viol != 0 || read_count != ereads) begin
         errors++;
         $display("FAIL bp_stability: node_unstable=%0d addr_unstable=%0d gaps=%0d reads=%0d want 0 0 0 %0d",
                  node_unstable, addr_unstable, gap_viol, read_count, ereads);
      end
   endtask

   task automatic test_reset_mid();
      bit reached;
      int kind, ereads;
      int unsigned ecost;
      setup_chain(); load_mem(8); mem_wait = 3; ready_mode = 0;
      clear_collectors();
      source = 8'd0; destination = 8'd7; number_of_nodes = 8'd8;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (req_start_count >= 5) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached || debug_state !== TRACER_READ_PREV) begin
         errors++;
         $display("FAIL midreset_setup: reached=%b state=%0d, want 1 READ_PREV", reached, debug_state);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_read_enable, mem_addr, path_node, path_valid, path_last, path_length,
           path_cost, done, no_path, loop_error} !== '0 || debug_state !== TRACER_IDLE) begin
         errors++;
         $display("FAIL midreset_outputs: en=%b addr=%h cost=%0d state=%0d, want all 0 and IDLE",
                  mem_read_enable, mem_addr, path_cost, debug_state);
      end
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      mem_wait = 0;
      model_trace(0, 7, 8, kind, ecost, ereads);
      run_dut(0, 7, 8, 1'b0);
      checks++;
      if (got_node_q != exp_q || path_cost !== 16'(ecost) || path_length !== 8'd8 || done !== 1'b1) begin
         errors++;
         $display("FAIL midreset_rerun: %0d nodes cost=%0d length=%0d done=%b, want %0d nodes cost=%0d 8 1",
                  got_node_q.size(), path_cost, path_length, done, exp_q.size(), ecost);
      end
   endtask

   task automatic test_random();
      int kind, ereads, n, s, d, total_bad;
      int unsigned ecost;
      total_bad = 0;
      for (int it = 0; it < 24; it++) begin
         n = $urandom_range(2, 16);
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
               graph_m[r][c] = ($urandom_range(0, 3) == 0) ? 16'(16'hF000 + $urandom_range(0, 4095))
                                                            : 16'($urandom_range(0, 300));
         if (it % 2 == 0) begin
            for (int j = 0; j < 16; j++) prev_m[j] = (j == 0) ? 8'hFF : 8'($urandom_range(0, j - 1));
            s = 0;
         end else begin
            for (int j = 0; j < 16; j++) begin
               case ($urandom_range(0, 9))
                  0:       prev_m[j] = 8'hFF;
                  1:       prev_m[j] = 8'(n + $urandom_range(0, 20));
                  default: prev_m[j] = 8'($urandom_range(0, n - 1));
               endcase
            end
            s = $urandom_range(0, n);
         end
         d = ($urandom_range(0, 7) == 0) ? n : $urandom_range(0, n - 1);
         load_mem(n);
         mem_wait = $urandom_range(0, 2);
         ready_mode = 2;
         model_trace(s, d, n, kind, ecost, ereads);
         run_dut(s, d, n, 1'b0);
         total_bad += addr_unstable + gap_viol + bad_addr + node_unstable;
         checks++;
         if (done !== 1'b1 || no_path !== (kind == 1) || loop_error !== (kind == 2) || read_count != ereads) begin
            errors++;
            $display("FAIL rand%0d_flags: done=%b no_path=%b loop=%b reads=%0d, want 1 %b %b %0d",
                     it, done, no_path, loop_error, read_count, (kind == 1), (kind == 2), ereads);
         end
         checks++;
         if (kind == 0) begin
            if (got_node_q != exp_q || got_last_q.size() == 0 || got_last_q[$] !== 1'b1 ||
                path_cost !== 16'(ecost) || path_length !== 8'(exp_q.size())) begin
               errors++;
               $display("FAIL rand%0d_path: %0d nodes cost=%0d length=%0d, want %0d nodes cost=%0d",
                        it, got_node_q.size(), path_cost, path_length, exp_q.size(), ecost);
            end
         end else if (valid_cycles != 0) begin
            errors++;
            $display("FAIL rand%0d_nostream: valid_cycles=%0d, want 0", it, valid_cycles);
         end
      end
      checks++;
      if (total_bad != 0) begin
         errors++;
         $display("FAIL rand_protocol: %0d handshake/stability violations, want 0", total_bad);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      checks = 0; errors = 0;
      mem_wait = 0; ready_mode = 0;
      reset = 1'b0; start = 1'b0;
      source = '0; destination = '0; number_of_nodes = '0;
      base_address = 32'h0000_1000 + 32'(4 * $urandom_range(0, 255));
      mem_read_ready = 1'b0; mem_read_data = '0; path_ready = 1'b1;
      clear_collectors();
      repeat (3) @(negedge clock);
      test_reset();
      test_chain();
      test_single();
      test_no_path();
      test_loop();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
